// File: rtl/mgmt_hub.sv
// mgmt_hub: management-bus interconnect between one mgmt master and NSLV slaves.
//
// Handshake (valid/ready semantics, all active high, sampled on posedge clk):
//   The master raises m_req with m_adr/m_rwn/m_wen/m_txd stable and holds them
//   until the cycle m_ack = 1; that cycle is the accept. For reads, exactly one
//   m_rxe pulse later returns m_rxd. Toward slave i, s_req[i] is held until the
//   slave answers with s_ack[i] (m_ack follows s_ack[sel] in the same cycle).
//   A read slave then pulses s_rxe[i] with s_rxd[i]. m_rxe/m_rxd are registered,
//   so they follow s_rxe one cycle later. m_rxd holds its value between pulses.
//   Only one transaction is outstanding. A request that arrives outside IDLE
//   waits until the hub is back in IDLE.
//
// Timeout: each wait phase (ack, read data) may last TIMEOUT cycles. If no
// response has come by the TIMEOUT-th cycle, the hub sends its own error
// response with m_rxd = ERR_DATA.
//
// Ports:
//   clk, rstn                     clock, async active-low reset
//   m_req/m_adr/m_rwn/m_wen/m_txd master request and fields
//   m_ack, m_rxe, m_rxd           master accept pulse, read valid, read data
//   s_req                         per-slave request (one-hot or zero)
//   s_adr/s_rwn/s_wen/s_txd       broadcast copies of the master fields
//   s_ack, s_rxe, s_rxd           per-slave ack, read valid, packed read data
//   err_vld/err_code/err_adr      sticky first-error status
//                                 (code 1 unmapped, 2 timeout, 3 stray/multi rxe)
//   err_clr                       clears the error status
//   dbg_state                     current FSM state (0 IDLE, 1 WAIT_ACK,
//                                 2 WAIT_RXD, 3 ERR_RSP)
module mgmt_hub #(
  parameter int                 NSLV     = 5,
  parameter logic [NSLV*32-1:0] SLV_BASE = {NSLV{32'h0}},
  parameter logic [NSLV*32-1:0] SLV_MASK = {NSLV{32'hFFFFF000}},
  parameter int                 TIMEOUT  = 255,
  parameter int                 TO_W     = 8,
  parameter logic [31:0]        ERR_DATA = 32'hDEADBEEF
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 m_req,
  input  logic [31:0]          m_adr,
  input  logic                 m_rwn,
  input  logic [1:0]           m_wen,
  input  logic [31:0]          m_txd,
  output logic                 m_ack,
  output logic                 m_rxe,
  output logic [31:0]          m_rxd,
  output logic [NSLV-1:0]      s_req,
  output logic [31:0]          s_adr,
  output logic                 s_rwn,
  output logic [1:0]           s_wen,
  output logic [31:0]          s_txd,
  input  logic [NSLV-1:0]      s_ack,
  input  logic [NSLV-1:0]      s_rxe,
  input  logic [NSLV*32-1:0]   s_rxd,
  output logic                 err_vld,
  output logic [1:0]           err_code,
  output logic [31:0]          err_adr,
  input  logic                 err_clr,
  output logic [1:0]           dbg_state
);

  localparam int              SEL_W  = (NSLV > 1) ? $clog2(NSLV) : 1;
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACK = 2'd1,
    WAIT_RXD = 2'd2,
    ERR_RSP  = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic [SEL_W-1:0]  sel, sel_dec;
  logic              hit;
  logic [31:0]       adr_q;
  logic              rwn_q;
  logic              phase_data;    // ERR_RSP answers the data phase (no m_ack)
  logic [TO_W-1:0]   cnt, cnt_inc;
  logic [NSLV-1:0]   sel_oh, rxe_win;
  logic              ack_sel, rxe_sel;
  logic [31:0]       rxd_sel;
  logic              rxe_ok, rxd_take, err_rxe, to_go, stray;
  logic              new_err;
  logic [1:0]        new_code;
  logic [31:0]       new_adr;

  // The master fields go to every slave. Only s_req qualifies them.
  assign s_adr     = m_adr;
  assign s_rwn     = m_rwn;
  assign s_wen     = m_wen;
  assign s_txd     = m_txd;
  assign dbg_state = state;

  // Address decode. The scan runs from high to low index, so on overlapping
  // windows the lowest index wins.
  always_comb begin
    sel_dec = '0;
    hit     = 1'b0;
    for (int i = NSLV - 1; i >= 0; i--) begin
      if ((m_adr & SLV_MASK[32*i +: 32]) == (SLV_BASE[32*i +: 32] & SLV_MASK[32*i +: 32])) begin
        sel_dec = SEL_W'(i);
        hit     = 1'b1;
      end
    end
  end

  // Per-slave view of the latched selection.
  always_comb begin
    sel_oh  = '0;
    rxd_sel = '0;
    for (int i = 0; i < NSLV; i++) begin
      sel_oh[i] = (sel == SEL_W'(i));
      if (sel == SEL_W'(i)) rxd_sel = s_rxd[32*i +: 32];
    end
  end

  assign ack_sel = |(s_ack & sel_oh);
  assign rxe_sel = |(s_rxe & sel_oh);

  // cnt_inc is the count including the current cycle. The timeout fires when
  // it reaches TIMEOUT.
  assign cnt_inc = (cnt == TO_MAX) ? cnt : cnt + 1'b1;

  // Next state and combinational outputs.
  always_comb begin
    state_nxt = state;
    s_req     = '0;
    m_ack     = 1'b0;
    rxe_ok    = 1'b0;
    rxd_take  = 1'b0;
    err_rxe   = 1'b0;
    to_go     = 1'b0;
    case (state)
      IDLE: begin
        if (m_req) state_nxt = hit ? WAIT_ACK : ERR_RSP;
      end
      WAIT_ACK: begin
        s_req = sel_oh;
        m_ack = ack_sel;
        // Read data is accepted together with the ack.
        rxe_ok = rwn_q && ack_sel;
        if (ack_sel) begin
          if (!rwn_q) begin
            state_nxt = IDLE;
          end else if (rxe_sel) begin
            state_nxt = IDLE;
            rxd_take  = 1'b1;
          end else begin
            state_nxt = WAIT_RXD;
          end
        end else if (cnt_inc == TO_MAX) begin
          state_nxt = ERR_RSP;
          to_go     = 1'b1;
        end
      end
      WAIT_RXD: begin
        rxe_ok = 1'b1;
        if (rxe_sel) begin
          state_nxt = IDLE;
          rxd_take  = 1'b1;
        end else if (cnt_inc == TO_MAX) begin
          state_nxt = ERR_RSP;
          to_go     = 1'b1;
        end
      end
      ERR_RSP: begin
        m_ack     = !phase_data;
        err_rxe   = phase_data || rwn_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // An rxe bit is stray unless it belongs to sel inside its valid window.
  assign rxe_win = rxe_ok ? sel_oh : '0;
  assign stray   = |(s_rxe & ~rxe_win);

  always_comb begin
    new_err  = 1'b0;
    new_code = 2'd0;
    new_adr  = adr_q;
    if (state == IDLE && m_req && !hit) begin
      new_err  = 1'b1;
      new_code = 2'd1;
      new_adr  = m_adr;
    end else if (to_go) begin
      new_err  = 1'b1;
      new_code = 2'd2;
    end else if (stray) begin
      new_err  = 1'b1;
      new_code = 2'd3;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      cnt        <= '0;
      sel        <= '0;
      adr_q      <= '0;
      rwn_q      <= 1'b0;
      phase_data <= 1'b0;
    end else begin
      state <= state_nxt;
      // The counter restarts on every state entry and saturates at TIMEOUT.
      if (state_nxt != state) cnt <= '0;
      else                    cnt <= cnt_inc;
      if (state == IDLE && m_req) begin
        sel   <= sel_dec;
        adr_q <= m_adr;
        rwn_q <= m_rwn;
      end
      if (state_nxt == ERR_RSP && state != ERR_RSP) phase_data <= (state == WAIT_RXD);
    end
  end

  // Registered read return.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_rxe <= 1'b0;
      m_rxd <= '0;
    end else begin
      m_rxe <= rxd_take || err_rxe;
      if (rxd_take)     m_rxd <= rxd_sel;
      else if (err_rxe) m_rxd <= ERR_DATA;
    end
  end

  // Sticky first error. A clear in the same cycle as a new error lets the
  // new error in.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_vld  <= 1'b0;
      err_code <= 2'd0;
      err_adr  <= '0;
    end else if (new_err && (!err_vld || err_clr)) begin
      err_vld  <= 1'b1;
      err_code <= new_code;
      err_adr  <= new_adr;
    end else if (err_clr) begin
      err_vld  <= 1'b0;
      err_code <= 2'd0;
      err_adr  <= '0;
    end
  end

endmodule

// File: tb/tb_mgmt_hub.sv
// Directed bench for mgmt_hub. Slave windows:
//   slave 0 0x0000/FFFFF000, slave 1 0x1000/FFFFF800, slave 2 0x2000/FFFFF000,
//   slave 3 0x3000/FFFFF000, slave 4 0x1000/FFFFF000.
// Slave 4 overlaps slave 1. TIMEOUT = 4.
module tb_mgmt_hub;
  localparam int NSLV = 5;
  localparam int TO   = 4;
  localparam logic [NSLV*32-1:0] BASES = {32'h1000, 32'h3000, 32'h2000, 32'h1000, 32'h0000};
  localparam logic [NSLV*32-1:0] MASKS = {32'hFFFFF000, 32'hFFFFF000, 32'hFFFFF000, 32'hFFFFF800, 32'hFFFFF000};
  localparam logic [31:0] ERRD = 32'hDEADBEEF;

  logic clk, rstn;
  logic m_req, m_rwn, m_ack, m_rxe, s_rwn, err_vld, err_clr;
  logic [31:0] m_adr, m_txd, m_rxd, s_adr, s_txd, err_adr;
  logic [1:0] m_wen, s_wen, err_code, dbg_state;
  logic [NSLV-1:0] s_req, s_ack, s_rxe;
  logic [NSLV*32-1:0] s_rxd;

  mgmt_hub #(.NSLV(NSLV), .SLV_BASE(BASES), .SLV_MASK(MASKS), .TIMEOUT(TO), .TO_W(8), .ERR_DATA(ERRD)) dut (
    .clk(clk), .rstn(rstn),
    .m_req(m_req), .m_adr(m_adr), .m_rwn(m_rwn), .m_wen(m_wen), .m_txd(m_txd),
    .m_ack(m_ack), .m_rxe(m_rxe), .m_rxd(m_rxd),
    .s_req(s_req), .s_adr(s_adr), .s_rwn(s_rwn), .s_wen(s_wen), .s_txd(s_txd),
    .s_ack(s_ack), .s_rxe(s_rxe), .s_rxd(s_rxd),
    .err_vld(err_vld), .err_code(err_code), .err_adr(err_adr), .err_clr(err_clr),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- model / scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [31:0]     exp_q[$];      // expected m_rxd values
  int              exp_cyc_q[$];  // cycle each m_rxe is due
  logic [NSLV-1:0] exp_sreq;
  logic            exp_ack;
  logic [31:0]     last_rxd;
  logic            mdl_vld;
  logic [1:0]      mdl_code;
  logic [31:0]     mdl_adr;
  logic [1:0]      pend_code;
  logic [31:0]     pend_adr;
  logic            pend_clr;
  bit              done_flag = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, act, exp_v);
    end
  endtask

  task automatic mdl_reset();
    exp_q.delete();
    exp_cyc_q.delete();
    last_rxd  = '0;
    mdl_vld   = 1'b0;
    mdl_code  = '0;
    mdl_adr   = '0;
    pend_code = '0;
    pend_adr  = '0;
    pend_clr  = 1'b0;
  endtask

  // Error-status model: the first error sticks, clear wipes it, and a clear
  // together with a new error keeps the new one.
  always @(posedge clk) begin
    cyc++;
    if (rstn) begin
      if (pend_code != 2'd0 && (!mdl_vld || pend_clr)) begin
        mdl_vld  = 1'b1;
        mdl_code = pend_code;
        mdl_adr  = pend_adr;
      end else if (pend_clr) begin
        mdl_vld  = 1'b0;
        mdl_code = '0;
        mdl_adr  = '0;
      end
    end
    pend_code = '0;
    pend_clr  = 1'b0;
  end

  // Compare process: every cycle, sampled on the falling edge.
  always @(negedge clk) begin : cmp
    bit now;
    now = (exp_cyc_q.size() > 0) && (exp_cyc_q[0] == cyc);
    chk("s_req", 32'(s_req), 32'(exp_sreq));
    chk("m_ack", 32'(m_ack), 32'(exp_ack));
    chk("m_rxe", 32'(m_rxe), 32'(now));
    if (now) begin
      chk("m_rxd", m_rxd, exp_q[0]);
      last_rxd = exp_q[0];
      void'(exp_q.pop_front());
      void'(exp_cyc_q.pop_front());
    end else begin
      chk("m_rxd_hold", m_rxd, last_rxd);
    end
    chk("err_vld", 32'(err_vld), 32'(mdl_vld));
    chk("err_code", 32'(err_code), 32'(mdl_code));
    chk("err_adr", err_adr, mdl_adr);
    chk("s_adr", s_adr, m_adr);
    chk("s_fields", {29'd0, s_rwn, s_wen}, {29'd0, m_rwn, m_wen});
    chk("s_txd", s_txd, m_txd);
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    s_ack    = '0;
    s_rxe    = '0;
    err_clr  = 1'b0;
    exp_sreq = '0;
    exp_ack  = 1'b0;
    for (int i = 0; i < NSLV; i++) s_rxd[32*i +: 32] = $urandom();
  endtask

  task automatic note_err(input logic [1:0] code, input logic [31:0] adr);
    if (pend_code == 2'd0) begin
      pend_code = code;
      pend_adr  = adr;
    end
  endtask

  task automatic sched_rxe(input logic [31:0] d);
    exp_q.push_back(d);
    exp_cyc_q.push_back(cyc + 1);
  endtask

  task automatic drive_rxe(input int slv, input logic [NSLV-1:0] mask, input logic [31:0] data,
                           input logic [31:0] adr);
    logic [NSLV-1:0] oh, m;
    oh = NSLV'(1) << slv;
    m  = (mask == '0) ? oh : mask;
    s_rxe = m;
    for (int i = 0; i < NSLV; i++) s_rxd[32*i +: 32] = (i == slv) ? data : ~data;
    if ((m & oh) != '0) sched_rxe(data);
    if ((m & ~oh) != '0) note_err(2'd3, adr);
  endtask

  task automatic do_clr();
    tick();
    err_clr  = 1'b1;
    pend_clr = 1'b1;
  endtask

  // One transaction. slv < 0 means the address is unmapped. ack_at is the
  // WAIT_ACK cycle (1-based) of the slave ack; 0 means no ack. rxe_at counts
  // cycles after the ack (0 = same cycle, -1 = never).
  task automatic txn(input logic [31:0] adr, input bit rd, input int slv, input int ack_at,
                     input int rxe_at, input logic [31:0] data, input logic [NSLV-1:0] mask,
                     input bit clr);
    logic [NSLV-1:0] oh;
    bit done;
    tick();
    m_req = 1'b1;
    m_adr = adr;
    m_rwn = rd;
    m_wen = rd ? 2'b00 : 2'b11;
    m_txd = $urandom();
    if (clr) begin
      err_clr  = 1'b1;
      pend_clr = 1'b1;
    end
    if (slv < 0) begin
      note_err(2'd1, adr);
      tick();
      exp_ack = 1'b1;
      if (rd) sched_rxe(ERRD);
      tick();
      m_req = 1'b0;
      return;
    end
    oh   = NSLV'(1) << slv;
    done = 0;
    for (int k = 1; k <= TO; k++) begin
      tick();
      exp_sreq = oh;
      if (k == ack_at) begin
        s_ack   = oh;
        exp_ack = 1'b1;
        done    = 1;
        if (rd && rxe_at == 0) drive_rxe(slv, mask, data, adr);
        break;
      end
      if (k == TO) note_err(2'd2, adr);
    end
    if (!done) begin
      tick();
      exp_ack = 1'b1;
      if (rd) sched_rxe(ERRD);
      tick();
      m_req = 1'b0;
      return;
    end
    if (!rd || rxe_at == 0) begin
      tick();
      m_req = 1'b0;
      return;
    end
    done = 0;
    for (int j = 1; j <= TO; j++) begin
      tick();
      m_req = 1'b0;
      if (j == rxe_at) begin
        drive_rxe(slv, mask, data, adr);
        done = 1;
        break;
      end
      if (j == TO) note_err(2'd2, adr);
    end
    if (!done) begin
      tick();
      sched_rxe(ERRD);
    end
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rstn = 1'b0; m_req = 1'b0; m_adr = '0; m_rwn = 1'b0; m_wen = '0; m_txd = '0;
    s_ack = '0; s_rxe = '0; s_rxd = '0; err_clr = 1'b0;
    exp_sreq = '0; exp_ack = 1'b0;
    mdl_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_state", 32'(dbg_state), 32'd0);
    chk("rst_rxd", m_rxd, 32'd0);
    @(posedge clk);
    #1 rstn = 1'b1;

    // Write to slave 2: s_req held 3 cycles, ack on the third.
    txn(32'h0000_2004, 1'b0, 2, 3, -1, '0, '0, 1'b0);
    @(negedge clk);
    chk("wr_no_err", 32'(err_vld), 32'd0);

    // Read slave 0: ack in cycle 1, data two cycles later.
    txn(32'h0000_0010, 1'b1, 0, 1, 2, 32'h1234_5678, '0, 1'b0);
    @(negedge clk);
    chk("rd0_rxe", 32'(m_rxe), 32'd1);
    chk("rd0_data", m_rxd, 32'h1234_5678);

    // Overlap: 0x1004 goes to slave 1 (lowest index), 0x1804 only to slave 4.
    txn(32'h0000_1004, 1'b1, 1, 1, 0, 32'hA5A5_0101, '0, 1'b0);
    txn(32'h0000_1804, 1'b0, 4, 2, -1, '0, '0, 1'b0);

    // Unmapped read.
    txn(32'hF000_0000, 1'b1, -1, 0, -1, '0, '0, 1'b0);
    tick();
    @(negedge clk);
    chk("unm_vld", 32'(err_vld), 32'd1);
    chk("unm_code", 32'(err_code), 32'd1);
    chk("unm_adr", err_adr, 32'hF000_0000);
    chk("unm_rxd", m_rxd, 32'hDEAD_BEEF);
    do_clr();

    // Write timeout on slave 3, then a late ack and a late rxe.
    txn(32'h0000_3000, 1'b0, 3, 0, -1, '0, '0, 1'b0);
    tick();
    s_ack = 5'b01000;
    tick();
    s_rxe = 5'b01000;
    note_err(2'd3, 32'h0000_3000);
    tick();
    @(negedge clk);
    chk("to_code", 32'(err_code), 32'd2);
    chk("to_adr", err_adr, 32'h0000_3000);
    do_clr();

    // Read-data timeout on slave 2.
    txn(32'h0000_2020, 1'b1, 2, 1, -1, '0, '0, 1'b0);
    do_clr();

    // Two rxe bits while waiting on slave 0: slave 0 data returned, code 3.
    txn(32'h0000_0040, 1'b1, 0, 1, 1, 32'hCAFE_0000, 5'b00011, 1'b0);
    @(negedge clk);
    chk("multi_data", m_rxd, 32'hCAFE_0000);
    tick();
    @(negedge clk);
    chk("multi_code", 32'(err_code), 32'd3);
    // A clear and an unmapped request in the same cycle: the new error is kept.
    txn(32'h0000_9000, 1'b0, -1, 0, -1, '0, '0, 1'b1);
    @(negedge clk);
    chk("clr_new_code", 32'(err_code), 32'd1);
    chk("clr_new_adr", err_adr, 32'h0000_9000);
    do_clr();
    tick();
    @(negedge clk);
    chk("clr_vld", 32'(err_vld), 32'd0);

    // Reset while waiting for read data, then a normal read.
    tick();
    m_req = 1'b1; m_adr = 32'h0000_2010; m_rwn = 1'b1; m_wen = 2'b00;
    tick();
    exp_sreq = 5'b00100; s_ack = 5'b00100; exp_ack = 1'b1;
    tick();
    m_req = 1'b0;
    tick();
    rstn = 1'b0;
    mdl_reset();
    @(negedge clk);
    chk("rst_mid_state", 32'(dbg_state), 32'd0);
    chk("rst_mid_rxd", m_rxd, 32'd0);
    tick();
    tick();
    rstn = 1'b1;
    txn(32'h0000_2008, 1'b1, 2, 2, 1, 32'h0BAD_F00D, '0, 1'b0);
    @(negedge clk);
    chk("post_rst_data", m_rxd, 32'h0BAD_F00D);

    tick();
    tick();
    @(negedge clk);
    done_flag = 1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    if (!done_flag) begin
      errors++;
      $display("FAIL watchdog cyc=%0d got=stalled expected=finished", cyc);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  end

endmodule
